// File: rtl/apb_ctrl_pkg.sv
// apb_ctrl_pkg
// Shared definitions for the APB master arbiter:
//   - apb_st_e      : bus sequencing FSM states
//   - sel_w()       : width of an encoded index for n items (never below 1)
//   - DEF_*         : default widths/counts used as module parameter defaults
package apb_ctrl_pkg;

    localparam int DEF_ADDR_WIDTH     = 32;
    localparam int DEF_DATA_WIDTH     = 32;
    localparam int DEF_NO_OF_SLAVES   = 4;
    localparam int DEF_NUM_REQ        = 4;
    localparam int DEF_TIMEOUT_CYCLES = 16;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_st_e;

    // Clamped to 1 so a single-slave build still has a legal decode slice.
    function automatic int sel_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// apb_rr_arbiter
// Purely combinational round-robin picker. The search starts one past the
// previous winner and wraps, so the last winner has the lowest priority.
// Ports:
//   req      in  NUM_REQ  request vector
//   last_gnt in  IDX_W    index of the previous winner (pointer held by parent)
//   en       in  1        allow a grant this cycle
//   gnt      out NUM_REQ  one-hot grant (all zero when en=0 or no request)
//   gnt_idx  out IDX_W    encoded index of gnt
module apb_rr_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W  = sel_w(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   last_gnt,
    input  logic               en,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   gnt_idx
);

    always_comb begin
        logic             found;
        logic [IDX_W-1:0] cand;
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        cand    = '0;
        // Offsets 1..NUM_REQ: the previous winner is visited last.
        for (int k = 1; k <= NUM_REQ; k++) begin
            cand = IDX_W'((int'(last_gnt) + k) % NUM_REQ);
            if (en && !found && req[cand]) begin
                found     = 1'b1;
                gnt[cand] = 1'b1;
                gnt_idx   = cand;
            end
        end
    end

endmodule

// File: rtl/apb_master_arbiter.sv
// apb_master_arbiter
// Shares one APB bus among NUM_REQ requesters: round-robin arbitration in
// IDLE, SETUP/ACCESS sequencing with wait-state timeout, one-cycle response
// pulse in RESP.
// Ports:
//   pclock, presetn            clock, synchronous active-low reset
//   req_valid/write/addr/wdata per-requester request (addr/wdata packed)
//   req_ready                  one-hot accept pulse (IDLE only)
//   rsp_valid/rdata/slverr     one-hot completion pulse with result
//   paddr/pwdata/pwrite/psel_x/penable  APB master outputs
//   prdata/pready/pslverr      APB slave responses
module apb_master_arbiter
    import apb_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH     = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int NO_OF_SLAVES   = DEF_NO_OF_SLAVES,
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                          pclock,
    input  logic                          presetn,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ-1:0]            req_write,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [DATA_WIDTH-1:0]         rsp_rdata,
    output logic                          rsp_slverr,
    output logic [ADDR_WIDTH-1:0]         paddr,
    output logic [DATA_WIDTH-1:0]         pwdata,
    output logic                          pwrite,
    output logic [NO_OF_SLAVES-1:0]       psel_x,
    output logic                          penable,
    input  logic [DATA_WIDTH-1:0]         prdata,
    input  logic                          pready,
    input  logic                          pslverr
);

    localparam int SEL_W = sel_w(NO_OF_SLAVES);
    localparam int IDX_W = sel_w(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    apb_st_e               st_reg, st_next;
    logic [ADDR_WIDTH-1:0] paddr_reg;
    logic [DATA_WIDTH-1:0] pwdata_reg;
    logic                  pwrite_reg;
    logic [IDX_W-1:0]      last_gnt_reg;   // also the owner of the current transfer
    logic [CNT_W-1:0]      wait_cnt_reg;
    logic [DATA_WIDTH-1:0] rdata_reg;
    logic                  slverr_reg;

    logic [ADDR_WIDTH-1:0] addr_arr  [NUM_REQ];
    logic [DATA_WIDTH-1:0] wdata_arr [NUM_REQ];
    logic [NUM_REQ-1:0]    gnt, owner_hot;
    logic [IDX_W-1:0]      gnt_idx;
    logic                  arb_en, gnt_any;
    logic [SEL_W-1:0]      sel_idx;
    logic [NO_OF_SLAVES-1:0] psel_dec;
    logic                  dec_ok;
    logic [CNT_W-1:0]      cnt_now;
    logic                  timeout_hit;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign addr_arr[gi]  = req_addr[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign wdata_arr[gi] = req_wdata[gi*DATA_WIDTH +: DATA_WIDTH];
            assign owner_hot[gi] = (last_gnt_reg == IDX_W'(gi));
        end
        // An index with no matching slave leaves psel_dec all-zero: decode error.
        for (gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_dec
            assign psel_dec[gi] = (sel_idx == SEL_W'(gi));
        end
    endgenerate

    assign sel_idx     = paddr_reg[ADDR_WIDTH-1 -: SEL_W];
    assign dec_ok      = |psel_dec;
    // Count of the current ACCESS cycle, 1 in the first one.
    assign cnt_now     = wait_cnt_reg + 1'b1;
    assign timeout_hit = (cnt_now == CNT_W'(TIMEOUT_CYCLES));
    // No grant while reset is applied, even though the state reads IDLE.
    assign arb_en      = (st_reg == ST_IDLE) && presetn;
    assign gnt_any     = |gnt;

    apb_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .req      (req_valid),
        .last_gnt (last_gnt_reg),
        .en       (arb_en),
        .gnt      (gnt),
        .gnt_idx  (gnt_idx)
    );

    // State register
    always_ff @(posedge pclock) begin
        if (!presetn) st_reg <= ST_IDLE;
        else          st_reg <= st_next;
    end

    // Next-state logic
    always_comb begin
        st_next = st_reg;
        case (st_reg)
            ST_IDLE:   if (gnt_any) st_next = ST_SETUP;
            ST_SETUP:  st_next = ST_ACCESS;
            ST_ACCESS: if (!dec_ok || pready || timeout_hit) st_next = ST_RESP;
            ST_RESP:   st_next = ST_IDLE;
            default:   st_next = ST_IDLE;
        endcase
    end

    // Outputs
    always_comb begin
        req_ready  = gnt;
        psel_x     = '0;
        penable    = 1'b0;
        rsp_valid  = '0;
        rsp_rdata  = '0;
        rsp_slverr = 1'b0;
        case (st_reg)
            ST_SETUP:  psel_x = psel_dec;
            ST_ACCESS: begin
                psel_x  = psel_dec;
                penable = 1'b1;
            end
            ST_RESP: begin
                rsp_valid  = owner_hot;
                rsp_rdata  = rdata_reg;
                rsp_slverr = slverr_reg;
            end
            default: ;
        endcase
    end

    assign paddr  = paddr_reg;
    assign pwdata = pwdata_reg;
    assign pwrite = pwrite_reg;

    // Request latch, wait counter and response capture
    always_ff @(posedge pclock) begin
        if (!presetn) begin
            paddr_reg    <= '0;
            pwdata_reg   <= '0;
            pwrite_reg   <= 1'b0;
            last_gnt_reg <= IDX_W'(NUM_REQ - 1);
            wait_cnt_reg <= '0;
            rdata_reg    <= '0;
            slverr_reg   <= 1'b0;
        end else begin
            case (st_reg)
                ST_IDLE: begin
                    wait_cnt_reg <= '0;
                    if (gnt_any) begin
                        paddr_reg    <= addr_arr[gnt_idx];
                        pwdata_reg   <= wdata_arr[gnt_idx];
                        pwrite_reg   <= req_write[gnt_idx];
                        last_gnt_reg <= gnt_idx;
                    end
                end
                ST_ACCESS: begin
                    if (!dec_ok) begin
                        slverr_reg   <= 1'b1;
                        rdata_reg    <= '0;
                        wait_cnt_reg <= '0;
                    end else if (pready) begin
                        // pready wins over a timeout landing in the same cycle
                        slverr_reg   <= pslverr;
                        rdata_reg    <= pwrite_reg ? '0 : prdata;
                        wait_cnt_reg <= '0;
                    end else if (timeout_hit) begin
                        slverr_reg   <= 1'b1;
                        rdata_reg    <= '0;
                        wait_cnt_reg <= '0;
                    end else begin
                        wait_cnt_reg <= cnt_now;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_apb_master_arbiter.sv
// tb_apb_master_arbiter
// Directed scenarios with hand-computed expectations for the APB master arbiter.
module tb_apb_master_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int NS = 4;
    localparam int NR = 4;
    localparam int TO = 16;

    logic              pclock;
    logic              presetn;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_write;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     req_ready;
    logic [NR-1:0]     rsp_valid;
    logic [DW-1:0]     rsp_rdata;
    logic              rsp_slverr;
    logic [AW-1:0]     paddr;
    logic [DW-1:0]     pwdata;
    logic              pwrite;
    logic [NS-1:0]     psel_x;
    logic              penable;
    logic [DW-1:0]     prdata;
    logic              pready;
    logic              pslverr;

    int n_checks = 0;
    int n_fail   = 0;

    apb_master_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NO_OF_SLAVES(NS),
        .NUM_REQ(NR), .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclock(pclock), .presetn(presetn),
        .req_valid(req_valid), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_valid(rsp_valid),
        .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr),
        .paddr(paddr), .pwdata(pwdata), .pwrite(pwrite),
        .psel_x(psel_x), .penable(penable),
        .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    initial pclock = 1'b0;
    always #5 pclock = ~pclock;

    task automatic tick();
        @(posedge pclock);
        #1;
    endtask

    task automatic set_req(input int i, input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req_write[i]          = w;
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
    endtask

    task automatic test_reset();
        presetn   = 1'b0;
        req_valid = 4'b1111;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_checks++;
            if ({req_ready, rsp_valid, psel_x, penable, pwrite, paddr, pwdata, rsp_rdata, rsp_slverr} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs c%0d: ready=%b rsp=%b psel=%b pen=%b pwrite=%b paddr=%h pwdata=%h rdata=%h err=%b, required all 0",
                         c, req_ready, rsp_valid, psel_x, penable, pwrite, paddr, pwdata, rsp_rdata, rsp_slverr);
            end
        end
        presetn = 1'b1;
        #1;
        n_checks++;
        if (req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b required 0001", req_ready);
        end
        tick();
        req_valid = '0;
        #1;
        n_checks++;
        if (psel_x !== 4'b0001 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_setup: psel=%b pen=%b required 0001/0", psel_x, penable);
        end
        tick(); tick();
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_first_rsp: rsp=%b err=%b required 0001/0", rsp_valid, rsp_slverr);
        end
        tick();
        $display("reset: done");
    endtask

    task automatic test_single_write();
        set_req(2, 1'b1, 32'h4000_0010, 32'hDEAD_BEEF);
        pready    = 1'b1;
        req_valid = 4'b0100;
        #1;
        n_checks++;
        if (req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL wr_ready: got %b required 0100", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (psel_x !== 4'b0010 || penable !== 1'b0 || paddr !== 32'h4000_0010 ||
            pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_setup: psel=%b pen=%b paddr=%h pwdata=%h pwrite=%b required 0010/0/40000010/deadbeef/1",
                     psel_x, penable, paddr, pwdata, pwrite);
        end
        tick();
        n_checks++;
        if (psel_x !== 4'b0010 || penable !== 1'b1) begin
            n_fail++;
            $display("FAIL wr_access: psel=%b pen=%b required 0010/1", psel_x, penable);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0100 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'h0 ||
            psel_x !== 4'b0000 || penable !== 1'b0) begin
            n_fail++;
            $display("FAIL wr_resp: rsp=%b err=%b rdata=%h psel=%b pen=%b required 0100/0/0/0000/0",
                     rsp_valid, rsp_slverr, rsp_rdata, psel_x, penable);
        end
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL wr_rsp_pulse: rsp=%b required 0000", rsp_valid);
        end
        $display("single_write: req2 addr=40000010 data=deadbeef");
    endtask

    task automatic test_read_wait();
        int acc;
        int bad_hold;
        bit got;
        acc = 0; bad_hold = 0; got = 0;
        set_req(1, 1'b0, 32'hC000_0004, 32'h0);
        prdata    = 32'h1234_5678;
        req_valid = 4'b0010;
        #1;
        n_checks++;
        if (req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL rd_ready: got %b required 0010", req_ready);
        end
        tick();
        req_valid = '0;
        pready    = 1'b0;
        n_checks++;
        if (psel_x !== 4'b1000 || pwrite !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_setup: psel=%b pwrite=%b required 1000/0", psel_x, pwrite);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (penable) begin
                acc++;
                if (psel_x !== 4'b1000 || paddr !== 32'hC000_0004) bad_hold++;
                pready = (acc == 4);
            end else if (rsp_valid != 0) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || acc != 4) begin
            n_fail++;
            $display("FAIL rd_access_len: got=%0d cycles (rsp seen=%0d) required 4", acc, got);
        end
        n_checks++;
        if (bad_hold != 0) begin
            n_fail++;
            $display("FAIL rd_hold: %0d cycles with unstable psel/paddr, required 0", bad_hold);
        end
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_rdata !== 32'h1234_5678 || rsp_slverr !== 1'b0) begin
            n_fail++;
            $display("FAIL rd_resp: rsp=%b rdata=%h err=%b required 0010/12345678/0", rsp_valid, rsp_rdata, rsp_slverr);
        end
        pready = 1'b1;
        tick();
        $display("read_wait: req1 addr=c0000004 access=%0d rdata=12345678", acc);
    endtask

    task automatic test_round_robin();
        int exp_order[5];
        int g, cyc, last_cyc;
        logic [NR-1:0] exp_hot;
        exp_order = '{0, 1, 2, 3, 0};
        g = 0; cyc = 0; last_cyc = 0;
        req_valid = '0;
        presetn   = 1'b0;
        tick();
        presetn = 1'b1;
        for (int i = 0; i < NR; i++) set_req(i, 1'b0, 32'h0000_0100 * (i + 1), 32'h0);
        pready    = 1'b1;
        req_valid = 4'b1111;
        #1;
        while (g < 5 && cyc < 40) begin
            if (req_ready != 0) begin
                exp_hot = 4'b0001 << exp_order[g];
                n_checks++;
                if (req_ready !== exp_hot) begin
                    n_fail++;
                    $display("FAIL rr_grant%0d: got %b required %b", g, req_ready, exp_hot);
                end
                if (g > 0) begin
                    n_checks++;
                    if (cyc - last_cyc != 4) begin
                        n_fail++;
                        $display("FAIL rr_spacing%0d: got %0d cycles required 4", g, cyc - last_cyc);
                    end
                end
                last_cyc = cyc;
                tick();
                cyc++;
                n_checks++;
                if (req_ready !== 4'b0000 || paddr !== 32'h0000_0100 * (exp_order[g] + 1)) begin
                    n_fail++;
                    $display("FAIL rr_pulse%0d: ready=%b paddr=%h required 0000/%h",
                             g, req_ready, paddr, 32'h0000_0100 * (exp_order[g] + 1));
                end
                $display("round_robin: grant %0d -> requester %0d", g, exp_order[g]);
                g++;
            end else begin
                tick();
                cyc++;
            end
        end
        n_checks++;
        if (g != 5) begin
            n_fail++;
            $display("FAIL rr_count: got %0d grants required 5 within 40 cycles", g);
        end
        req_valid = '0;
        repeat (4) tick();
    endtask

    task automatic test_timeout();
        int acc;
        bit got;
        acc = 0; got = 0;
        set_req(3, 1'b0, 32'h8000_0000, 32'h0);
        prdata    = 32'hAAAA_5555;
        pready    = 1'b0;
        req_valid = 4'b1000;
        #1;
        n_checks++;
        if (req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL to_ready: got %b required 1000", req_ready);
        end
        tick();
        req_valid = '0;
        n_checks++;
        if (psel_x !== 4'b0100) begin
            n_fail++;
            $display("FAIL to_setup: psel=%b required 0100", psel_x);
        end
        for (int c = 0; c < 40; c++) begin
            tick();
            if (penable) acc++;
            else if (rsp_valid != 0) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || acc != TO) begin
            n_fail++;
            $display("FAIL to_access_len: got=%0d (rsp seen=%0d) required %0d", acc, got, TO);
        end
        n_checks++;
        if (rsp_valid !== 4'b1000 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL to_resp: rsp=%b err=%b rdata=%h required 1000/1/0", rsp_valid, rsp_slverr, rsp_rdata);
        end
        tick();
        n_checks++;
        if ({psel_x, penable, rsp_valid} !== '0) begin
            n_fail++;
            $display("FAIL to_idle: psel=%b pen=%b rsp=%b required all 0", psel_x, penable, rsp_valid);
        end
        pready = 1'b1;
        $display("timeout: req3 access=%0d slverr=1", acc);
    endtask

    task automatic test_timeout_boundary();
        int acc;
        bit got;
        acc = 0; got = 0;
        set_req(0, 1'b0, 32'h0000_0008, 32'h0);
        prdata    = 32'hAAAA_5555;
        pready    = 1'b0;
        req_valid = 4'b0001;
        #1;
        tick();
        req_valid = '0;
        for (int c = 0; c < 40; c++) begin
            tick();
            if (penable) begin
                acc++;
                pready = (acc == TO);
            end else if (rsp_valid != 0) begin
                got = 1;
                break;
            end
        end
        n_checks++;
        if (!got || acc != TO) begin
            n_fail++;
            $display("FAIL tob_access_len: got=%0d (rsp seen=%0d) required %0d", acc, got, TO);
        end
        n_checks++;
        if (rsp_valid !== 4'b0001 || rsp_slverr !== 1'b0 || rsp_rdata !== 32'hAAAA_5555) begin
            n_fail++;
            $display("FAIL tob_resp: rsp=%b err=%b rdata=%h required 0001/0/aaaa5555", rsp_valid, rsp_slverr, rsp_rdata);
        end
        pready = 1'b1;
        tick();
        $display("timeout_boundary: req0 pready on cycle %0d completes normally", acc);
    endtask

    task automatic test_slverr();
        set_req(1, 1'b1, 32'h4000_0020, 32'h0000_00FF);
        pready    = 1'b1;
        pslverr   = 1'b1;
        req_valid = 4'b0010;
        #1;
        tick();
        req_valid = '0;
        tick();
        tick();
        n_checks++;
        if (rsp_valid !== 4'b0010 || rsp_slverr !== 1'b1 || rsp_rdata !== 32'h0) begin
            n_fail++;
            $display("FAIL slverr_resp: rsp=%b err=%b rdata=%h required 0010/1/0", rsp_valid, rsp_slverr, rsp_rdata);
        end
        pslverr = 1'b0;
        tick();
        $display("slverr: req1 write pslverr=1 -> rsp_slverr=1");
    endtask

    task automatic test_reset_abort();
        int stray;
        stray = 0;
        set_req(2, 1'b1, 32'hC000_0000, 32'h5A5A_5A5A);
        pready    = 1'b0;
        req_valid = 4'b0100;
        #1;
        tick();
        req_valid = '0;
        tick();
        n_checks++;
        if (penable !== 1'b1 || psel_x !== 4'b1000) begin
            n_fail++;
            $display("FAIL abort_access: pen=%b psel=%b required 1/1000", penable, psel_x);
        end
        presetn = 1'b0;
        tick();
        n_checks++;
        if (psel_x !== 4'b0000 || penable !== 1'b0 || rsp_valid !== 4'b0000) begin
            n_fail++;
            $display("FAIL abort_idle: psel=%b pen=%b rsp=%b required 0000/0/0000", psel_x, penable, rsp_valid);
        end
        presetn = 1'b1;
        pready  = 1'b1;
        repeat (4) begin
            tick();
            if (rsp_valid != 0 || psel_x != 0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++;
            $display("FAIL abort_no_rsp: %0d cycles with rsp_valid/psel after abort, required 0", stray);
        end
        $display("reset_abort: req2 abandoned in ACCESS");
    endtask

    initial begin
        presetn   = 1'b0;
        req_valid = '0;
        req_write = '0;
        req_addr  = '0;
        req_wdata = '0;
        prdata    = '0;
        pready    = 1'b1;
        pslverr   = 1'b0;
        test_reset();
        test_single_write();
        test_read_wait();
        test_round_robin();
        test_timeout();
        test_timeout_boundary();
        test_slverr();
        test_reset_abort();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within 200000 time units");
        $fatal(1, "watchdog expired");
    end

endmodule
